// File: rtl/alu_addr_data_latch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_addr_data_latch: 16-bit data latch, registered address mux and 8-bit |
// | ALU with NV1BDIZC flags. ALU_DECIMAL_EN enables BCD ADC/SBC.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_addr_data_latch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  dl_data_in,
  input  logic        dl_latch_l,
  input  logic        dl_latch_h,
  input  logic        dl_inc,
  output logic [15:0] dl_out,
  input  logic [1:0]  addr_sel,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] addr2,
  input  logic [15:0] addr3,
  output logic [15:0] a,
  input  logic [7:0]  alu_data_in,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  arg_sel,
  input  logic [7:0]  arg0,
  input  logic [7:0]  arg1,
  input  logic [7:0]  arg2,
  input  logic [7:0]  arg3,
  input  logic [7:0]  arg4,
  input  logic [7:0]  arg5,
  input  logic [7:0]  arg6,
  input  logic [7:0]  arg7,
  input  logic [7:0]  sr,
  output logic [7:0]  alu_data_out,
  output logic [7:0]  sr_data,
  output logic [1:0]  b_sr
);

  localparam logic [3:0] OP_PASSB = 4'h0;
  localparam logic [3:0] OP_ADC   = 4'h1;
  localparam logic [3:0] OP_SBC   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_ORA   = 4'h4;
  localparam logic [3:0] OP_EOR   = 4'h5;
  localparam logic [3:0] OP_ASL   = 4'h6;
  localparam logic [3:0] OP_LSR   = 4'h7;
  localparam logic [3:0] OP_ROL   = 4'h8;
  localparam logic [3:0] OP_ROR   = 4'h9;
  localparam logic [3:0] OP_INC   = 4'hA;
  localparam logic [3:0] OP_DEC   = 4'hB;
  localparam logic [3:0] OP_CMP   = 4'hC;
  localparam logic [3:0] OP_BIT   = 4'hD;
  localparam logic [3:0] OP_PASSA = 4'hE;

  localparam logic [7:0] SR_RESET = 8'h24;

  logic [15:0] dl_q, dl_d;
  logic [15:0] a_q;
  logic [7:0]  res_q, res_d;
  logic [7:0]  sr_q, sr_d;
  logic [1:0]  bsr_q, bsr_d;

  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [7:0]  add_b;
  logic [8:0]  sum9;
  logic [7:0]  bin_r;
  logic        bin_v;
  logic [7:0]  cmp_diff;
  logic [7:0]  nz_src;
  logic        upd_nz;
  logic        dec_mode;
  logic [7:0]  dec_r;
  logic        dec_c;

  always_comb begin
    dl_d = dl_q;
    if (dl_latch_l || dl_latch_h) begin
      if (dl_latch_l) dl_d[7:0]  = dl_data_in;
      if (dl_latch_h) dl_d[15:8] = dl_data_in;
    end else if (dl_inc) begin
      dl_d = dl_q + 16'd1;
    end
  end

  always_comb begin
    case (arg_sel)
      3'd0:    op_a = arg0;
      3'd1:    op_a = arg1;
      3'd2:    op_a = arg2;
      3'd3:    op_a = arg3;
      3'd4:    op_a = arg4;
      3'd5:    op_a = arg5;
      3'd6:    op_a = arg6;
      default: op_a = arg7;
    endcase
  end

  assign op_b     = alu_data_in;
  // SBC is A + ~B + C; V is judged against the operand actually added.
  assign add_b    = (alu_op == OP_SBC) ? ~op_b : op_b;
  assign sum9     = {1'b0, op_a} + {1'b0, add_b} + {8'd0, sr[0]};
  assign bin_r    = sum9[7:0];
  assign bin_v    = ((op_a[7] ^ bin_r[7]) & (add_b[7] ^ bin_r[7]));
  assign cmp_diff = op_a - op_b;

`ifdef ALU_DECIMAL_EN
  logic [5:0] dec_lo;
  logic [5:0] dec_hi;
  logic       dec_lo_c;

  assign dec_mode = sr[3];

  always_comb begin
    dec_lo   = 6'd0;
    dec_hi   = 6'd0;
    dec_lo_c = 1'b0;
    dec_r    = bin_r;
    dec_c    = sum9[8];
    if (alu_op == OP_SBC) begin
      dec_lo   = {2'b00, op_a[3:0]} - {2'b00, op_b[3:0]} - {5'd0, ~sr[0]};
      dec_lo_c = dec_lo[5];
      if (dec_lo_c) dec_lo = dec_lo - 6'd6;
      dec_hi = {2'b00, op_a[7:4]} - {2'b00, op_b[7:4]} - {5'd0, dec_lo_c};
      if (dec_hi[5]) dec_hi = dec_hi - 6'd6;
      dec_r = {dec_hi[3:0], dec_lo[3:0]};
      dec_c = sum9[8];
    end else begin
      dec_lo = {2'b00, op_a[3:0]} + {2'b00, op_b[3:0]} + {5'd0, sr[0]};
      if (dec_lo > 6'd9) dec_lo = dec_lo + 6'd6;
      dec_lo_c = (dec_lo[5:4] != 2'b00);
      dec_hi = {2'b00, op_a[7:4]} + {2'b00, op_b[7:4]} + {5'd0, dec_lo_c};
      if (dec_hi > 6'd9) dec_hi = dec_hi + 6'd6;
      dec_r = {dec_hi[3:0], dec_lo[3:0]};
      dec_c = (dec_hi[5:4] != 2'b00);
    end
  end
`else
  assign dec_mode = 1'b0;
  assign dec_r    = bin_r;
  assign dec_c    = sum9[8];
`endif

  always_comb begin
    res_d  = op_a;
    sr_d   = sr | 8'h20;
    nz_src = op_a;
    upd_nz = 1'b1;
    case (alu_op)
      OP_PASSB: res_d = op_b;
      OP_ADC, OP_SBC: begin
        res_d   = dec_mode ? dec_r : bin_r;
        nz_src  = bin_r;
        sr_d[0] = dec_mode ? dec_c : sum9[8];
        sr_d[6] = bin_v;
      end
      OP_AND: res_d = op_a & op_b;
      OP_ORA: res_d = op_a | op_b;
      OP_EOR: res_d = op_a ^ op_b;
      OP_ASL: begin
        res_d   = {op_a[6:0], 1'b0};
        sr_d[0] = op_a[7];
      end
      OP_LSR: begin
        res_d   = {1'b0, op_a[7:1]};
        sr_d[0] = op_a[0];
      end
      OP_ROL: begin
        res_d   = {op_a[6:0], sr[0]};
        sr_d[0] = op_a[7];
      end
      OP_ROR: begin
        res_d   = {sr[0], op_a[7:1]};
        sr_d[0] = op_a[0];
      end
      OP_INC: res_d = op_a + 8'd1;
      OP_DEC: res_d = op_a - 8'd1;
      OP_CMP: begin
        nz_src  = cmp_diff;
        sr_d[0] = (op_a >= op_b);
      end
      OP_BIT: begin
        upd_nz  = 1'b0;
        sr_d[7] = op_b[7];
        sr_d[6] = op_b[6];
        sr_d[1] = ((op_a & op_b) == 8'd0);
      end
      OP_PASSA: res_d = op_a;
      default:  upd_nz = 1'b0;
    endcase
    if (alu_op inside {OP_PASSB, OP_AND, OP_ORA, OP_EOR, OP_ASL, OP_LSR,
                       OP_ROL, OP_ROR, OP_INC, OP_DEC, OP_PASSA}) begin
      nz_src = res_d;
    end
    if (upd_nz) begin
      sr_d[7] = nz_src[7];
      sr_d[1] = (nz_src == 8'd0);
    end
  end

  // Page-cross helper: unsigned carry of A+B and sign of the branch offset.
  assign bsr_d = {op_b[7], (({1'b0, op_a} + {1'b0, op_b}) > 9'd255)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_q  <= 16'h0000;
      a_q   <= 16'h0000;
      res_q <= 8'h00;
      sr_q  <= SR_RESET;
      bsr_q <= 2'b00;
    end else begin
      dl_q <= dl_d;
      case (addr_sel)
        2'd0:    a_q <= addr0;
        2'd1:    a_q <= addr1;
        2'd2:    a_q <= addr2;
        default: a_q <= addr3;
      endcase
      res_q <= res_d;
      sr_q  <= sr_d;
      bsr_q <= bsr_d;
    end
  end

  assign dl_out       = dl_q;
  assign a            = a_q;
  assign alu_data_out = res_q;
  assign sr_data      = sr_q;
  assign b_sr         = bsr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_addr_data_latch.sv
`default_nettype none
// Directed bench for alu_addr_data_latch: ALU vector table plus latch,
// address and reset sequences.
module tb_alu_addr_data_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  dl_data_in;
  logic        dl_latch_l, dl_latch_h, dl_inc;
  logic [15:0] dl_out;
  logic [1:0]  addr_sel;
  logic [15:0] addr [4];
  logic [15:0] a;
  logic [7:0]  alu_data_in;
  logic [3:0]  alu_op;
  logic [2:0]  arg_sel;
  logic [7:0]  arg [8];
  logic [7:0]  sr_v;
  logic [7:0]  alu_data_out, sr_data;
  logic [1:0]  b_sr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_addr_data_latch dut (
    .clk(clk), .rst_n(rst_n),
    .dl_data_in(dl_data_in), .dl_latch_l(dl_latch_l), .dl_latch_h(dl_latch_h),
    .dl_inc(dl_inc), .dl_out(dl_out),
    .addr_sel(addr_sel), .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]),
    .addr3(addr[3]), .a(a),
    .alu_data_in(alu_data_in), .alu_op(alu_op), .arg_sel(arg_sel),
    .arg0(arg[0]), .arg1(arg[1]), .arg2(arg[2]), .arg3(arg[3]),
    .arg4(arg[4]), .arg5(arg[5]), .arg6(arg[6]), .arg7(arg[7]),
    .sr(sr_v), .alu_data_out(alu_data_out), .sr_data(sr_data), .b_sr(b_sr)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sr;
    logic [7:0] r;
    logic [7:0] f;
    logic [1:0] bsr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'h1, 8'h50, 8'h50, 8'h20, 8'hA0, 8'hE0, 2'b00}; // ADC overflow
    vecs[1]  = '{4'h1, 8'hFF, 8'h01, 8'h20, 8'h00, 8'h23, 2'b01}; // ADC wrap
    vecs[2]  = '{4'h2, 8'h50, 8'h30, 8'h21, 8'h20, 8'h21, 2'b00};
    vecs[3]  = '{4'h2, 8'h00, 8'h01, 8'h21, 8'hFF, 8'hA0, 2'b00};
    vecs[4]  = '{4'h3, 8'hF0, 8'h3C, 8'hC3, 8'h30, 8'h61, 2'b01};
    vecs[5]  = '{4'h4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 2'b00};
    vecs[6]  = '{4'h5, 8'hFF, 8'h7F, 8'h00, 8'h80, 8'hA0, 2'b01};
    vecs[7]  = '{4'h6, 8'h81, 8'h00, 8'h00, 8'h02, 8'h21, 2'b00};
    vecs[8]  = '{4'h7, 8'h01, 8'h80, 8'h80, 8'h00, 8'h23, 2'b10};
    vecs[9]  = '{4'h8, 8'h40, 8'h00, 8'h01, 8'h81, 8'hA0, 2'b00};
    vecs[10] = '{4'h9, 8'h03, 8'h00, 8'h01, 8'h81, 8'hA1, 2'b00};
    vecs[11] = '{4'hA, 8'hFF, 8'h00, 8'h81, 8'h00, 8'h23, 2'b00}; // INC wrap
    vecs[12] = '{4'hB, 8'h00, 8'h00, 8'h02, 8'hFF, 8'hA0, 2'b00}; // DEC wrap
    vecs[13] = '{4'hC, 8'h40, 8'h40, 8'h40, 8'h40, 8'h63, 2'b00};
    vecs[14] = '{4'hC, 8'h10, 8'h20, 8'h01, 8'h10, 8'hA0, 2'b00};
    vecs[15] = '{4'hD, 8'h01, 8'hC0, 8'h00, 8'h01, 8'hE2, 2'b10};
    vecs[16] = '{4'h0, 8'h55, 8'h00, 8'h80, 8'h00, 8'h22, 2'b00};
    vecs[17] = '{4'hE, 8'h80, 8'h12, 8'h02, 8'h80, 8'hA0, 2'b00};
    vecs[18] = '{4'hF, 8'h33, 8'hF0, 8'hFF, 8'h33, 8'hFF, 2'b11};
`ifdef ALU_DECIMAL_EN
    vecs[19] = '{4'h1, 8'h19, 8'h28, 8'h28, 8'h47, 8'h28, 2'b00};
    vecs[20] = '{4'h1, 8'h99, 8'h01, 8'h28, 8'h00, 8'hA9, 2'b00};
`else
    vecs[19] = '{4'h1, 8'h19, 8'h28, 8'h28, 8'h41, 8'h28, 2'b00};
    vecs[20] = '{4'h1, 8'h99, 8'h01, 8'h28, 8'h9A, 8'hA8, 2'b00};
`endif

    rst_n = 1'b0;
    dl_data_in = 8'h00; dl_latch_l = 1'b0; dl_latch_h = 1'b0; dl_inc = 1'b0;
    addr[0] = 16'h1234; addr[1] = 16'hABCD; addr[2] = 16'hDEAD; addr[3] = 16'hBEEF;
    addr_sel = 2'd1;
    alu_data_in = 8'h7F; alu_op = 4'h1; arg_sel = 3'd0; sr_v = 8'hFF;
    for (int k = 0; k < 8; k++) arg[k] = 8'hF0;

    // Reset state with live inputs
    step();
    step();
    chk("rst_dl", dl_out, 16'h0000);
    chk("rst_a", a, 16'h0000);
    chk("rst_alu", {8'h00, alu_data_out}, 16'h0000);
    chk("rst_sr", {8'h00, sr_data}, 16'h0024);
    chk("rst_bsr", {14'd0, b_sr}, 16'h0000);
    rst_n = 1'b1;
    addr_sel = 2'd0;

    // Data latch: full load, wrap, latch suppresses inc
    dl_latch_l = 1'b1; dl_latch_h = 1'b1; dl_data_in = 8'hFF;
    step(); chk("dl_load_ffff", dl_out, 16'hFFFF);
    dl_latch_l = 1'b0; dl_latch_h = 1'b0; dl_inc = 1'b1;
    step(); chk("dl_inc_wrap", dl_out, 16'h0000);
    dl_latch_l = 1'b1; dl_data_in = 8'h12;
    step(); chk("dl_latchl_noinc", dl_out, 16'h0012);
    dl_latch_l = 1'b0;
    step(); chk("dl_inc", dl_out, 16'h0013);
    dl_latch_h = 1'b1; dl_data_in = 8'hAB;
    step(); chk("dl_latchh_noinc", dl_out, 16'hAB13);
    dl_latch_h = 1'b0; dl_inc = 1'b0;
    step(); chk("dl_hold", dl_out, 16'hAB13);

    // Address select, one cycle latency
    for (int s = 0; s < 4; s++) begin
      addr_sel = 2'(s);
      step();
      chk($sformatf("addr_sel%0d", s), a, addr[s]);
    end

    // ALU vector table; operand A placed on a rotating arg slot
    for (int i = 0; i < NV; i++) begin
      arg_sel = 3'(i % 8);
      for (int k = 0; k < 8; k++) arg[k] = ~vecs[i].a;
      arg[i % 8] = vecs[i].a;
      alu_data_in = vecs[i].b;
      alu_op = vecs[i].op;
      sr_v = vecs[i].sr;
      step();
      chk($sformatf("v%0d_res", i), {8'h00, alu_data_out}, {8'h00, vecs[i].r});
      chk($sformatf("v%0d_sr", i), {8'h00, sr_data}, {8'h00, vecs[i].f});
      chk($sformatf("v%0d_bsr", i), {14'd0, b_sr}, {14'd0, vecs[i].bsr});
    end

    // Reset during active operations, then normal first edge
    for (int k = 0; k < 8; k++) arg[k] = 8'h50;
    arg_sel = 3'd0; alu_data_in = 8'h50; alu_op = 4'h1; sr_v = 8'hF7;
    dl_latch_l = 1'b1; dl_latch_h = 1'b1; dl_inc = 1'b1; dl_data_in = 8'h5A;
    addr_sel = 2'd2;
    rst_n = 1'b0;
    step();
    chk("mid_rst_dl", dl_out, 16'h0000);
    chk("mid_rst_a", a, 16'h0000);
    chk("mid_rst_alu", {8'h00, alu_data_out}, 16'h0000);
    chk("mid_rst_sr", {8'h00, sr_data}, 16'h0024);
    chk("mid_rst_bsr", {14'd0, b_sr}, 16'h0000);
    rst_n = 1'b1;
    step();
    chk("post_rst_dl", dl_out, 16'h5A5A);
    chk("post_rst_a", a, 16'hDEAD);
    chk("post_rst_alu", {8'h00, alu_data_out}, 16'h00A1);
    chk("post_rst_sr", {8'h00, sr_data}, 16'h00F4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_addr_data_latch.md
ALU_ADDR_DATA_LATCH -- requirements
Module: alu_addr_data_latch

Interface
REQ-001 The block SHALL use clock clk (rising edge) and reset rst_n, which is synchronous and active-low.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  clock
 rst_n  in  1  synchronous active-low reset
 dl_data_in  in  8  byte loaded into the data latch
 dl_latch_l  in  1  load dl_out[7:0]
 dl_latch_h  in  1  load dl_out[15:8]
 dl_inc  in  1  increment dl_out
 dl_out  out  16  data-latch value
 addr_sel  in  2  address source select
 addr0..addr3  in  16 each  address candidates
 a  out  16  registered address bus
 alu_data_in  in  8  ALU operand B (memory byte)
 alu_op  in  4  ALU operation
 arg_sel  in  3  selects operand A from arg0..arg7
 arg0..arg7  in  8 each  operand A candidates
 sr  in  8  current status NV1BDIZC
 alu_data_out  out  8  registered ALU result
 sr_data  out  8  registered updated status
 b_sr  out  2  registered branch helper flags

Function
REQ-003 Data latch SHALL be clocked; each edge applies the following in priority order: latch_l loads dl_out[7:0] from dl_data_in; latch_h loads dl_out[15:8] from dl_data_in (both may assert together); otherwise dl_inc adds 1 modulo 2^16 (0xFFFF -> 0x0000); otherwise dl_out holds.
REQ-004 Any asserted latch SHALL suppress dl_inc for that cycle.
REQ-005 Address latch SHALL update a <= addr[addr_sel] on every edge, with 1-cycle latency and no hold condition.
REQ-006 Operand A SHALL be arg[arg_sel] and operand B SHALL be alu_data_in.
REQ-007 The ALU SHALL compute a result R and new flags combinationally, then register them into alu_data_out and sr_data on every edge (latency 1).
REQ-008 Opcodes SHALL be:
 - 0 PASSB (R=B)
 - 1 ADC (A+B+C)
 - 2 SBC (A+~B+C)
 - 3 AND
 - 4 ORA
 - 5 EOR
 - 6 ASL A
 - 7 LSR A
 - 8 ROL A
 - 9 ROR A
 - A INC A
 - B DEC A
 - C CMP
 - D BIT
 - E PASSA (R=A)
 - F NOP (R=A, sr_data=sr)
REQ-009 Flag rules (NZ always means N=R[7], Z=(R==0)):
 - All ops except CMP, BIT and NOP update NZ.
 - ADC/SBC set C to the bit-8 carry and V=((A^R)&(B'^R))[7], where B' is the operand actually added.
 - Shift/rotate ops set C to the bit shifted out; rotates take the incoming bit from sr.C.
 - CMP: R=A, NZ taken from A-B, C=(A>=B unsigned), V unchanged.
 - BIT: R=A, Z=((A&B)==0), N=B[7], V=B[6].
REQ-010 sr_data bits not updated by the op SHALL equal sr, except that bit 5 SHALL be forced to 1.
REQ-011 b_sr SHALL be registered every edge: b_sr[0] = carry out of (A+B) unsigned 8-bit add; b_sr[1] = B[7]. These flags are used for branch offset page-cross detection.
REQ-012 Wrap-around SHALL be modulo 256 for all 8-bit ops: INC 0xFF -> 0x00 and DEC 0x00 -> 0xFF.

Reset
REQ-013 While rst_n=0 at an edge, the block SHALL set dl_out=0x0000, a=0x0000, alu_data_out=0x00, sr_data=0x24 and b_sr=0; reset SHALL override all load, inc and select inputs.
REQ-014 Reset asserted mid-operation SHALL discard any pending result, and the first edge after release SHALL behave normally.

Configuration
REQ-015 With macro ALU_DECIMAL_EN defined, ADC and SBC SHALL apply BCD adjustment when sr[3] (D) is 1, as follows:
 - ADC: add 6 to the low nibble if it is >9 or carried; add 0x60 if the high result is >9 or carried; C = decimal carry.
 - SBC: subtract 6 from each nibble that borrowed; C = no-borrow.
 - N, Z and V are taken from the binary result.
REQ-016 Without ALU_DECIMAL_EN, the D flag SHALL be ignored and ADC/SBC SHALL be binary only.

Verification
REQ-017 Data-latch wrap: latch_l=latch_h=1 with data 0xFF, then dl_inc for 1 cycle -> dl_out=0xFFFF then 0x0000; latch_l with inc and data 0x12 -> low byte 0x12, no increment.
REQ-018 Address select: addr0..3 = 0x1234/0xABCD/0xDEAD/0xBEEF, addr_sel = 0,1,2,3 on successive cycles -> a shows each value one cycle after its select.
REQ-019 ADC overflow: A=0x50, B=0x50, C=0, ADC -> alu_data_out=0xA0, N=1, V=1, Z=0, C=0; A=0xFF, B=0x01 -> R=0x00, Z=1, C=1.
REQ-020 CMP/BIT: A=0x40, B=0x40, CMP -> Z=1, C=1, R=0x40; A=0x01, B=0xC0, BIT -> Z=1, N=1, V=1.
REQ-021 Decimal (macro on): D=1, A=0x19, B=0x28, C=0, ADC -> R=0x47, C=0; A=0x99, B=0x01 -> R=0x00, C=1. With the macro off, the same stimulus -> R=0x41, then 0x9A.
REQ-022 Reset: assert rst_n=0 during active ops -> next edge gives dl_out=0, a=0, alu_data_out=0, sr_data=0x24, b_sr=0.
